// File: rtl/barrel_pkg.sv
// Shared mode encodings and helpers for the pipelined barrel shifter.
package barrel_pkg;

    localparam logic [2:0] MODE_SLL = 3'd0;
    localparam logic [2:0] MODE_SRL = 3'd1;
    localparam logic [2:0] MODE_SRA = 3'd2;
    localparam logic [2:0] MODE_ROL = 3'd3;
    localparam logic [2:0] MODE_ROR = 3'd4;

    function automatic logic mode_illegal(input logic [2:0] mode);
        return mode > MODE_ROR;
    endfunction

endpackage

// File: rtl/barrel_shift_stage.sv
// One combinational shift/rotate step by a fixed distance DIST.
module barrel_shift_stage
    import barrel_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             en_i,
    input  logic [2:0]       mode_i,
    input  logic             sign_i,
    output logic [WIDTH-1:0] data_o
);

    always_comb begin
        data_o = data_i;
        if (en_i) begin
            case (mode_i)
                MODE_SLL: data_o = data_i << DIST;
                MODE_SRL: data_o = data_i >> DIST;
                MODE_SRA: data_o = {{DIST{sign_i}}, data_i[WIDTH-1:DIST]};
                MODE_ROL: data_o = {data_i[WIDTH-1-DIST:0], data_i[WIDTH-1:WIDTH-DIST]};
                MODE_ROR: data_o = {data_i[DIST-1:0], data_i[WIDTH-1:DIST]};
                // illegal modes pass the operand through untouched
                default:  data_o = data_i;
            endcase
        end
    end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: one register stage per shift-amount bit, valid/ready
// handshake with whole-pipeline stall when the consumer back-pressures.
module barrel_shifter_pipe
    import barrel_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in,
    input  logic [SHW-1:0]   ctrl,
    input  logic [2:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_err
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
        logic [SHW-1:0]   ctrl;
        logic [2:0]       mode;
        logic             err;
        logic             sign;
    } stage_t;

    stage_t           src     [SHW];
    stage_t           stage_d [SHW];
    stage_t           stage_q [SHW];
    logic [WIDTH-1:0] shifted [SHW];
    logic             adv;

    assign adv      = out_ready || !stage_q[SHW-1].valid;
    assign in_ready = adv;

    // src[k] is what feeds stage k: the ports for k=0, else the previous register
    always_comb begin
        src[0] = '{valid: in_valid, data: in, ctrl: ctrl, mode: mode,
                   err: mode_illegal(mode), sign: in[WIDTH-1]};
        for (int unsigned k = 1; k < SHW; k++) begin
            src[k] = stage_q[k-1];
        end
    end

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        barrel_shift_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_stage (
            .data_i (src[k].data),
            .en_i   (src[k].ctrl[k]),
            .mode_i (src[k].mode),
            .sign_i (src[k].sign),
            .data_o (shifted[k])
        );
    end

    always_comb begin
        for (int unsigned k = 0; k < SHW; k++) begin
            stage_d[k]      = src[k];
            stage_d[k].data = shifted[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < SHW; k++) begin
                stage_q[k] <= '0;
            end
        end else if (adv) begin
            for (int unsigned k = 0; k < SHW; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign out_valid = stage_q[SHW-1].valid;
    assign out       = stage_q[SHW-1].data;
    assign out_err   = stage_q[SHW-1].err;

endmodule
